// File: rtl/us_interp.sv
// ============================================================================
// Module      : us_interp
// Description : Parametrised baseband upsampler. Takes W-bit symbols over a
//               valid/ready handshake into a one-entry holding buffer and
//               emits one output word per enabled clock. Each symbol is
//               followed by L-1 fill words. The fill is either zeros
//               (zero-insertion, i_mode=0) or the repeated symbol
//               (sample-and-hold, i_mode=1).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : W      symbol / output width in bits (>= 1)
//               L      upsampling factor (>= 2, any integer)
// Ports       : clk         rising-edge clock
//               rst_n       asynchronous active-low reset
//               i_en        run enable; low freezes o_dout and clears phase
//               i_mode      0 = zero-insertion, 1 = sample-and-hold
//               i_din       input symbol
//               i_din_vld   input symbol valid
//               o_din_rdy   holding buffer empty, symbol can be taken
//               o_dout      upsampled output word
//               o_dout_vld  o_dout is a live word this cycle
//               o_dout_stb  o_dout carries a new symbol (phase 0)
//               o_underrun  one-cycle pulse: phase 0 reached, buffer empty
// Options     : US_SYNC_EN  when defined, i_en and i_mode each pass through
//                           a two-flop synchronizer (reset to 0) before use
// ============================================================================
`default_nettype none

module us_interp #(
  parameter int W = 2,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_mode,
  input  logic [W-1:0] i_din,
  input  logic         i_din_vld,
  output logic         o_din_rdy,
  output logic [W-1:0] o_dout,
  output logic         o_dout_vld,
  output logic         o_dout_stb,
  output logic         o_underrun
);

  // Phase counter width is derived from L and is not meant to be overridden.
  localparam int CNT_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(L - 1);

  // --------------------------------------------------------------------------
  // Control inputs: direct or synchronized
  // --------------------------------------------------------------------------
  logic w_en;
  logic w_mode;

`ifdef US_SYNC_EN
  logic r_en_s1;
  logic r_en_s2;
  logic r_mode_s1;
  logic r_mode_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_mode_s1 <= 1'b0;
      r_mode_s2 <= 1'b0;
    end else begin
      r_en_s1   <= i_en;
      r_en_s2   <= r_en_s1;
      r_mode_s1 <= i_mode;
      r_mode_s2 <= r_mode_s1;
    end
  end

  assign w_en   = r_en_s2;
  assign w_mode = r_mode_s2;
`else
  assign w_en   = i_en;
  assign w_mode = i_mode;
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_hold;
  logic             r_buf_full;
  logic [W-1:0]     r_last;
  logic [W-1:0]     r_dout;
  logic             r_dout_vld;
  logic             r_dout_stb;
  logic             r_underrun;

  logic w_accept;
  logic w_phase0;
  logic w_consume;

  // Ready comes straight from the buffer flag, so there is no combinational
  // path from i_din_vld to o_din_rdy. Because ready is low whenever the
  // buffer is full, accept and consume can never happen on the same edge.
  assign w_accept  = i_din_vld & ~r_buf_full;
  assign w_phase0  = (r_cnt == '0);
  assign w_consume = w_en & w_phase0 & r_buf_full;

  // Phase counter: wraps at L-1 while enabled, parks at 0 while disabled so
  // the first enabled cycle always lands on phase 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!w_en) begin
      r_cnt <= '0;
    end else if (r_cnt == c_CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // One-entry holding buffer. Acceptance does not depend on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_buf_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold     <= i_din;
        r_buf_full <= 1'b1;
      end else if (w_consume) begin
        r_buf_full <= 1'b0;
      end
    end
  end

  // Output path. At phase 0 a buffered symbol is emitted and remembered in
  // r_last for sample-and-hold fill; an empty buffer emits zero, clears
  // r_last (so hold-mode fill is also zero) and flags an underrun.
  // While disabled o_dout keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_last     <= '0;
      r_dout_vld <= 1'b0;
      r_dout_stb <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_dout_vld <= w_en;
      if (w_en) begin
        if (w_phase0) begin
          if (r_buf_full) begin
            r_dout     <= r_hold;
            r_last     <= r_hold;
            r_dout_stb <= 1'b1;
            r_underrun <= 1'b0;
          end else begin
            r_dout     <= '0;
            r_last     <= '0;
            r_dout_stb <= 1'b0;
            r_underrun <= 1'b1;
          end
        end else begin
          r_dout     <= w_mode ? r_last : '0;
          r_dout_stb <= 1'b0;
          r_underrun <= 1'b0;
        end
      end else begin
        r_dout_stb <= 1'b0;
        r_underrun <= 1'b0;
      end
    end
  end

  assign o_din_rdy  = ~r_buf_full;
  assign o_dout     = r_dout;
  assign o_dout_vld = r_dout_vld;
  assign o_dout_stb = r_dout_stb;
  assign o_underrun = r_underrun;

endmodule

`default_nettype wire
